// File: rtl/bc_pkg.sv
// Shared state encoding, segment constants and hex font for the Bulls-and-Cows core.
package bc_pkg;

  typedef enum logic [2:0] {LOAD, GUESS, COMPARE, RESULT, WIN, LOSE} state_t;

  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_P    = 8'h73;
  localparam logic [7:0] SEG_L    = 8'h38;
  localparam logic [7:0] SEG_DP   = 8'h80;

  // gfedcba, active-high
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/bc_game_core_if.sv
// Pad-side bus of the game core: raw switches/buttons in, display and status out.
interface bc_game_core_if #(
  parameter int NDIG      = 4,
  parameter int DW        = 3,
  parameter int MAX_TRIES = 10
);
  localparam int CW = $clog2(NDIG + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic [NDIG*DW-1:0] digits_in;
  logic               save_in;
  logic               newgame_in;
  logic [7:0]         seg_out;
  logic [CW-1:0]      bulls;
  logic [CW-1:0]      cows;
  logic [TW-1:0]      tries;
  logic               result_valid;
  logic               err;
  logic               win;
  logic               lose;

  modport master (
    output digits_in, save_in, newgame_in,
    input  seg_out, bulls, cows, tries, result_valid, err, win, lose
  );

  modport slave (
    input  digits_in, save_in, newgame_in,
    output seg_out, bulls, cows, tries, result_valid, err, win, lose
  );
endinterface

// File: rtl/bc_btn_sync.sv
// Multi-flop synchroniser plus history flop; emits a one-cycle pulse on the synced rising edge.
module bc_btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_pulse
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_hist;
endmodule

// File: rtl/bc_game_core.sv
// Bulls-and-Cows engine: synchronised pads, sequential pairwise scoring, win/lose and display.
module bc_game_core import bc_pkg::*; #(
  parameter int NDIG        = 4,
  parameter int DW          = 3,
  parameter int MAX_TRIES   = 10,
  parameter int SYNC_STAGES = 2,
  parameter int ALLOW_DUP   = 0,
  parameter int DISP_DIV    = 1024
) (
  input logic          clk,
  input logic          rst_n,
  bc_game_core_if.slave bus
);
  localparam int CW = $clog2(NDIG + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int IW = $clog2(NDIG);
  localparam int VW = $clog2(DISP_DIV);
  localparam int BW = NDIG * DW;

  logic [SYNC_STAGES-1:0][BW-1:0] r_dsync;
  logic [BW-1:0] w_digits;
  logic          w_save_p, w_newgame_p, w_dup;

  state_t        r_state;
  logic [7:0]    r_seg;
  logic [BW-1:0] r_secret, r_guess;
  logic [IW-1:0] r_i, r_j;
  logic [CW-1:0] r_bacc, r_cacc, r_bulls, r_cows;
  logic [TW-1:0] r_tries;
  logic          r_rv, r_err, r_win, r_lose;
  logic [VW-1:0] r_div;
  logic          r_phase;

  logic [DW-1:0] w_gd, w_sd;
  logic          w_hit, w_last;
  logic [CW-1:0] w_bulls_nx, w_cows_nx;

  bc_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_save_sync (
    .clk(clk), .rst_n(rst_n), .i_raw(bus.save_in), .o_pulse(w_save_p)
  );
  bc_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_newgame_sync (
    .clk(clk), .rst_n(rst_n), .i_raw(bus.newgame_in), .o_pulse(w_newgame_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_dsync <= '0;
    else        r_dsync <= {r_dsync[SYNC_STAGES-2:0], bus.digits_in};
  end
  assign w_digits = r_dsync[SYNC_STAGES-1];

  always_comb begin
    w_dup = 1'b0;
    for (int unsigned a = 0; a < NDIG; a++)
      for (int unsigned b = a + 1; b < NDIG; b++)
        if (w_digits[a*DW +: DW] == w_digits[b*DW +: DW]) w_dup = 1'b1;
    if (ALLOW_DUP != 0) w_dup = 1'b0;
  end

  assign w_gd       = r_guess[r_i*DW +: DW];
  assign w_sd       = r_secret[r_j*DW +: DW];
  assign w_hit      = (w_gd == w_sd);
  assign w_last     = (r_i == IW'(NDIG-1)) && (r_j == IW'(NDIG-1));
  assign w_bulls_nx = r_bacc + CW'(w_hit && (r_i == r_j));
  // Repeated digits can match many pairs; clamp so the cow count stays in range.
  assign w_cows_nx  = (w_hit && (r_i != r_j) && (r_cacc != CW'(NDIG))) ? r_cacc + 1'b1 : r_cacc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= LOAD;
      r_seg    <= SEG_DASH;
      r_secret <= '0;
      r_guess  <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_bacc   <= '0;
      r_cacc   <= '0;
      r_bulls  <= '0;
      r_cows   <= '0;
      r_tries  <= '0;
      r_rv     <= 1'b0;
      r_err    <= 1'b0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
      r_div    <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_rv  <= 1'b0;
      r_err <= 1'b0;
      if (w_newgame_p) begin
        r_state <= LOAD;
        r_seg   <= SEG_DASH;
        r_tries <= '0;
        r_bulls <= '0;
        r_cows  <= '0;
        r_win   <= 1'b0;
        r_lose  <= 1'b0;
      end else begin
        unique case (r_state)
          LOAD: if (w_save_p) begin
            if (w_dup) r_err <= 1'b1;
            else begin
              r_secret <= w_digits;
              r_state  <= GUESS;
              r_seg    <= SEG_DASH | SEG_DP;
            end
          end
          GUESS, RESULT: begin
            // RESULT shares GUESS entry; an accepted save below overrides the display update.
            if (r_state == RESULT) begin
              if (r_div == VW'(DISP_DIV-1)) begin
                r_div   <= '0;
                r_phase <= ~r_phase;
                r_seg   <= r_phase ? {1'b0, hex7(4'(r_bulls))} : {1'b1, hex7(4'(r_cows))};
              end else begin
                r_div <= r_div + 1'b1;
              end
            end
            if (w_save_p) begin
              if (w_dup) r_err <= 1'b1;
              else begin
                r_guess <= w_digits;
                r_state <= COMPARE;
                r_seg   <= SEG_DASH | SEG_DP;
                if (r_tries != TW'(MAX_TRIES)) r_tries <= r_tries + 1'b1;
                r_i    <= '0;
                r_j    <= '0;
                r_bacc <= '0;
                r_cacc <= '0;
              end
            end
          end
          COMPARE: begin
            r_bacc <= w_bulls_nx;
            r_cacc <= w_cows_nx;
            if (r_j == IW'(NDIG-1)) begin
              r_j <= '0;
              r_i <= w_last ? '0 : r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
            if (w_last) begin
              r_bulls <= w_bulls_nx;
              r_cows  <= w_cows_nx;
              r_rv    <= 1'b1;
              if (w_bulls_nx == CW'(NDIG)) begin
                r_state <= WIN;
                r_seg   <= SEG_P;
                r_win   <= 1'b1;
              end else if (r_tries == TW'(MAX_TRIES)) begin
                r_state <= LOSE;
                r_seg   <= SEG_L;
                r_lose  <= 1'b1;
              end else begin
                r_state <= RESULT;
                r_seg   <= {1'b0, hex7(4'(w_bulls_nx))};
                r_div   <= '0;
                r_phase <= 1'b0;
              end
            end
          end
          WIN, LOSE: ;
          default: r_state <= LOAD;
        endcase
      end
    end
  end

  assign bus.seg_out      = r_seg;
  assign bus.bulls        = r_bulls;
  assign bus.cows         = r_cows;
  assign bus.tries        = r_tries;
  assign bus.result_valid = r_rv;
  assign bus.err          = r_err;
  assign bus.win          = r_win;
  assign bus.lose         = r_lose;
endmodule

// File: tb/tb_bc_game_core.sv
// Directed bench for bc_game_core: two configurations, scoreboard of expected scores per DUT.
module tb_bc_game_core;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bc_game_core_if #(.NDIG(4), .DW(3), .MAX_TRIES(10)) ifa ();
  bc_game_core_if #(.NDIG(4), .DW(3), .MAX_TRIES(3))  ifb ();

  bc_game_core #(.NDIG(4), .DW(3), .MAX_TRIES(10), .SYNC_STAGES(2), .ALLOW_DUP(0), .DISP_DIV(8))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bc_game_core #(.NDIG(4), .DW(3), .MAX_TRIES(3), .SYNC_STAGES(2), .ALLOW_DUP(1), .DISP_DIV(8))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  typedef struct { int b; int c; int t; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int   seen_a = 0;
  int   seen_b = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && ifa.result_valid === 1'b1) begin
      seen_a++;
      chk("sb_a_pending", 32'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("sb_a_bulls", 32'(ifa.bulls), e.b);
        chk("sb_a_cows",  32'(ifa.cows),  e.c);
        chk("sb_a_tries", 32'(ifa.tries), e.t);
      end
    end
    if (rst_n === 1'b1 && ifb.result_valid === 1'b1) begin
      seen_b++;
      chk("sb_b_pending", 32'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("sb_b_bulls", 32'(ifb.bulls), e.b);
        chk("sb_b_cows",  32'(ifb.cows),  e.c);
        chk("sb_b_tries", 32'(ifb.tries), e.t);
      end
    end
  end

  function automatic logic [11:0] cd(input int d0, input int d1, input int d2, input int d3);
    return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic [11:0] code, input bit sv, input bit ng);
    if (sel) begin
      ifb.digits_in = code; ifb.save_in = sv; ifb.newgame_in = ng;
    end else begin
      ifa.digits_in = code; ifa.save_in = sv; ifa.newgame_in = ng;
    end
  endtask

  // Buttons act on the third edge after assertion; returns just after that edge.
  task automatic press(input bit sel, input logic [11:0] code, input bit sv, input bit ng);
    drive(sel, code, sv, ng);
    tick(3);
    drive(sel, code, 1'b0, 1'b0);
  endtask

  task automatic wait_rv(input bit sel, output int n);
    logic rv;
    n  = 0;
    rv = 1'b0;
    while (!rv && n < 40) begin
      tick(1);
      n++;
      rv = sel ? ifb.result_valid : ifa.result_valid;
    end
    chk(sel ? "rv_seen_b" : "rv_seen_a", 32'(rv), 1);
  endtask

  task automatic guess(input bit sel, input logic [11:0] code, input int b, input int c, input int t);
    exp_t e;
    int   n;
    e.b = b; e.c = c; e.t = t;
    if (sel) qb.push_back(e); else qa.push_back(e);
    press(sel, code, 1'b1, 1'b0);
    wait_rv(sel, n);
    chk(sel ? "lat_b" : "lat_a", 32'(n), 16);
  endtask

  task automatic chk_reset_a(input string pfx);
    chk({pfx, "_seg"},   32'(ifa.seg_out), 32'h40);
    chk({pfx, "_bulls"}, 32'(ifa.bulls), 0);
    chk({pfx, "_cows"},  32'(ifa.cows), 0);
    chk({pfx, "_tries"}, 32'(ifa.tries), 0);
    chk({pfx, "_rv"},    32'(ifa.result_valid), 0);
    chk({pfx, "_err"},   32'(ifa.err), 0);
    chk({pfx, "_win"},   32'(ifa.win), 0);
    chk({pfx, "_lose"},  32'(ifa.lose), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, '0, 1'b0, 1'b0);
    tick(3);
    chk_reset_a("rst");
    rst_n = 1'b1;
    tick(1);

    // Save latency and single pulse while held
    drive(1'b0, cd(1,2,3,4), 1'b1, 1'b0);
    tick(2);
    chk("load_before_edge3", 32'(ifa.seg_out), 32'h40);
    tick(1);
    chk("load_at_edge3", 32'(ifa.seg_out), 32'hC0);
    tick(10);
    chk("held_save_seg", 32'(ifa.seg_out), 32'hC0);
    chk("held_save_tries", 32'(ifa.tries), 0);
    drive(1'b0, cd(1,2,3,4), 1'b0, 1'b0);
    tick(3);

    // Duplicate guess rejected in GUESS
    press(1'b0, cd(5,5,0,1), 1'b1, 1'b0);
    chk("dup_err", 32'(ifa.err), 1);
    chk("dup_tries", 32'(ifa.tries), 0);
    tick(1);
    chk("dup_err_pulse", 32'(ifa.err), 0);
    chk("dup_stay_guess", 32'(ifa.seg_out), 32'hC0);
    tick(3);

    // Scored guess and display alternation
    guess(1'b0, cd(1,3,2,7), 1, 2, 1);
    chk("disp_bulls0", 32'(ifa.seg_out), 32'h06);
    tick(1);
    chk("rv_one_cycle", 32'(ifa.result_valid), 0);
    tick(6);
    chk("disp_bulls_end", 32'(ifa.seg_out), 32'h06);
    tick(1);
    chk("disp_cows", 32'(ifa.seg_out), 32'hDB);
    tick(8);
    chk("disp_bulls_again", 32'(ifa.seg_out), 32'h06);

    // New game from RESULT
    press(1'b0, cd(1,3,2,7), 1'b0, 1'b1);
    chk("ng_seg", 32'(ifa.seg_out), 32'h40);
    chk("ng_tries", 32'(ifa.tries), 0);
    chk("ng_bulls", 32'(ifa.bulls), 0);
    chk("ng_cows", 32'(ifa.cows), 0);
    tick(3);

    // Newgame together with save in GUESS: newgame wins
    press(1'b0, cd(1,2,3,4), 1'b1, 1'b0);
    tick(3);
    press(1'b0, cd(1,2,3,4), 1'b1, 1'b1);
    chk("ngsave_seg", 32'(ifa.seg_out), 32'h40);
    chk("ngsave_tries", 32'(ifa.tries), 0);
    tick(20);
    chk("ngsave_tries_late", 32'(ifa.tries), 0);

    // Win, then further saves ignored
    press(1'b0, cd(1,2,3,4), 1'b1, 1'b0);
    tick(3);
    guess(1'b0, cd(1,2,3,4), 4, 0, 1);
    chk("win_flag", 32'(ifa.win), 1);
    chk("win_seg", 32'(ifa.seg_out), 32'h73);
    tick(3);
    press(1'b0, cd(5,6,7,0), 1'b1, 1'b0);
    tick(20);
    chk("win_hold_tries", 32'(ifa.tries), 1);
    chk("win_hold_flag", 32'(ifa.win), 1);
    chk("win_hold_seg", 32'(ifa.seg_out), 32'h73);

    // Reset in the middle of COMPARE
    press(1'b0, cd(0,0,0,0), 1'b0, 1'b1);
    tick(3);
    press(1'b0, cd(1,2,3,4), 1'b1, 1'b0);
    tick(3);
    press(1'b0, cd(1,3,2,7), 1'b1, 1'b0);
    tick(5);
    chk("mid_cmp_tries", 32'(ifa.tries), 1);
    rst_n = 1'b0;
    tick(1);
    chk_reset_a("midrst");
    rst_n = 1'b1;
    tick(20);
    chk("midrst_no_result", 32'(ifa.tries), 0);

    // ALLOW_DUP=1, MAX_TRIES=3 configuration
    press(1'b1, cd(5,6,0,2), 1'b1, 1'b0);
    tick(3);
    chk("b_guess_seg", 32'(ifb.seg_out), 32'hC0);
    guess(1'b1, cd(5,5,0,1), 2, 1, 1);
    chk("b_dup_no_err", 32'(ifb.err), 0);
    guess(1'b1, cd(0,0,0,0), 1, 3, 2);
    guess(1'b1, cd(7,7,7,7), 0, 0, 3);
    chk("b_lose_flag", 32'(ifb.lose), 1);
    chk("b_lose_seg", 32'(ifb.seg_out), 32'h38);
    chk("b_lose_win", 32'(ifb.win), 0);
    tick(3);
    press(1'b1, cd(0,0,0,0), 1'b0, 1'b1);
    chk("b_ng_seg", 32'(ifb.seg_out), 32'h40);
    chk("b_ng_tries", 32'(ifb.tries), 0);
    chk("b_ng_lose", 32'(ifb.lose), 0);
    tick(3);

    chk("sb_a_drained", 32'(qa.size()), 0);
    chk("sb_b_drained", 32'(qb.size()), 0);
    chk("results_a", 32'(seen_a), 2);
    chk("results_b", 32'(seen_b), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
